dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-port 64-word data memory (dmem) between the processor data port and a debug/loader port.
- CPU normally owns the memory.
- The debug port is served in idle cycles, after a bounded starvation wait, or for a locked multi-word burst.
- Sits between datapath DM_* signals and dmem. Drives a stall back to the processor whenever its access is deferred.

Parameters:
N, 64, data word width.
AW, 6, word-address width (dmem depth 2**AW).
STARVE_MAX, 4, consecutive denied debug cycles before debug is forced a grant.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
cpu_req  in  1  CPU access valid (DM_readEnable | DM_writeEnable).
cpu_we  in  1  CPU write (DM_writeEnable).
cpu_addr  in  N  CPU byte address; word index = cpu_addr[AW+2:3].
cpu_wdata  in  N  CPU write data.
cpu_rdata  out  N  CPU read data, combinational from mem_readData.
cpu_stall  out  1  CPU access not performed this cycle; CPU holds PC and request.
dbg_req  in  1  debug access valid.
dbg_we  in  1  debug write.
dbg_lock  in  1  keep debug ownership for following cycles (burst).
dbg_addr  in  AW  debug word address.
dbg_wdata  in  N  debug write data.
dbg_gnt  out  1  debug access performed this cycle.
dbg_rdata  out  N  registered debug read data.
dbg_rvalid  out  1  dbg_rdata valid (one cycle after a granted debug read).
mem_addr  out  AW  to dmem address.
mem_writeData  out  N  to dmem writeData.
mem_memWrite  out  1  to dmem memWrite.
mem_memRead  out  1  to dmem memRead.
mem_readData  in  N  from dmem readData (combinational read).

Behaviour:
- FSM states: CPU_OWN, DBG_OWN. Starve counter sc, width clog2(STARVE_MAX+1).
- Grant (combinational, per cycle):
  - In CPU_OWN: dbg_gnt = dbg_req & (~cpu_req | sc == STARVE_MAX). cpu granted = cpu_req & ~dbg_gnt.
  - In DBG_OWN: dbg_gnt = dbg_req. CPU never granted.
- cpu_stall = cpu_req & ~cpu_granted.
- Mux: granted requester drives mem_addr/mem_writeData. mem_memWrite = granted & we; mem_memRead = granted & ~we.
  - No grant: mem_memWrite = 0, mem_memRead = 0, mem_addr = 0, mem_writeData = 0.
- cpu_rdata = mem_readData always. CPU uses it only when not stalled; zero added latency on the CPU path.
- Transitions:
  - CPU_OWN -> DBG_OWN when dbg_gnt & dbg_lock.
  - DBG_OWN -> CPU_OWN when ~dbg_req | ~dbg_lock. The cycle in which dbg_req & ~dbg_lock is still granted (last beat).
- sc update:
  - reset to 0 on any dbg_gnt or when ~dbg_req.
  - +1 when dbg_req & ~dbg_gnt, saturating at STARVE_MAX.
  - held at 0 in DBG_OWN.
- dbg_rvalid <= dbg_gnt & ~dbg_we. dbg_rdata <= mem_readData when dbg_gnt & ~dbg_we, else hold.
- Simultaneous requests with sc < STARVE_MAX: CPU wins, debug waits. Worst-case debug wait = STARVE_MAX cycles.
- While CPU stalled, requester inputs must be stable. The arbiter does not latch CPU request fields.
- cpu_addr bits other than [AW+2:3] are ignored; no alignment check.
- Reset (sync, any state, mid-burst included): state CPU_OWN, sc 0, dbg_rvalid 0, dbg_rdata 0. Combinational outputs follow from the reset state and current inputs.

Decomposition:
- Shared package dmem_arb_pkg:
  - typedef enum logic {CPU_OWN, DBG_OWN} arb_state_t.
  - localparam DEF_STARVE_MAX = 4.
  - function word_index(addr) extracting [AW+2:3].
- One natural sub-module: starve_counter (saturating counter with clear/increment/max flag). Grant mux and FSM stay in dmem_arbiter.

Test Plan:
- Reset, cpu_req=1, cpu_we=1, cpu_addr=0x18, cpu_wdata=0xAA, dbg_req=0 -> mem_addr=3, mem_memWrite=1, cpu_stall=0. Readback via cpu read of 0x18 -> cpu_rdata=0xAA same cycle.
- cpu_req=0, dbg read addr 3 -> dbg_gnt=1 that cycle; next cycle dbg_rvalid=1, dbg_rdata=0xAA.
- cpu_req and dbg_req held high, no lock -> CPU granted 4 cycles (cpu_stall=0, sc 1..4); cycle 5 dbg_gnt=1, cpu_stall=1; cycle 6 CPU granted, sc=0.
- dbg burst: dbg_lock=1 with writes 0x10,0x20,0x30 to addrs 0..2 while cpu_req=1 -> cpu_stall=1 for 3 cycles. dbg_lock drops on 3rd beat -> 4th cycle CPU granted. Memory holds written values.
- reset asserted mid-burst in DBG_OWN -> next cycle state CPU_OWN, dbg_rvalid=0, dbg_rdata=0, cpu_req alone not stalled.
- dbg write (dbg_we=1) granted -> dbg_rvalid stays 0 next cycle, dbg_rdata unchanged.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter between the CPU data
// port and the debug/loader port.
package dmem_arb_pkg;

    localparam int DEF_N          = 64;
    localparam int DEF_AW         = 6;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic {
        CPU_OWN = 1'b0,
        DBG_OWN = 1'b1
    } arb_state_t;

    // CPU addresses are byte addresses of 8-byte words; only the word index bits reach dmem.
    function automatic logic [DEF_AW-1:0] word_index(input logic [DEF_N-1:0] addr);
        return addr[DEF_AW+2:3];
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive denied debug cycles; at_max forces a debug grant.
module starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic at_max
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (incr && (count != W'(MAX))) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count == W'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between the CPU data port (default owner) and
// the debug port (idle cycles, starvation-forced grants, locked bursts).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int AW         = DEF_AW,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [N-1:0]  cpu_addr,
    input  logic [N-1:0]  cpu_wdata,
    output logic [N-1:0]  cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_lock,
    input  logic [AW-1:0] dbg_addr,
    input  logic [N-1:0]  dbg_wdata,
    output logic          dbg_gnt,
    output logic [N-1:0]  dbg_rdata,
    output logic          dbg_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_writeData,
    output logic          mem_memWrite,
    output logic          mem_memRead,
    input  logic [N-1:0]  mem_readData
);

    arb_state_t state;
    arb_state_t state_next;
    logic       cpu_gnt;
    logic       sc_max;

    starve_counter #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .clear (dbg_gnt || !dbg_req || (state == DBG_OWN)),
        .incr  (dbg_req && !dbg_gnt),
        .at_max(sc_max)
    );

    always_comb begin
        dbg_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (state == DBG_OWN) begin
            dbg_gnt = dbg_req;
        end else begin
            dbg_gnt = dbg_req && (!cpu_req || sc_max);
            cpu_gnt = cpu_req && !dbg_gnt;
        end
    end

    assign cpu_stall = cpu_req && !cpu_gnt;
    assign cpu_rdata = mem_readData;

    always_comb begin
        mem_addr      = '0;
        mem_writeData = '0;
        mem_memWrite  = 1'b0;
        mem_memRead   = 1'b0;
        if (dbg_gnt) begin
            mem_addr      = dbg_addr;
            mem_writeData = dbg_wdata;
            mem_memWrite  = dbg_we;
            mem_memRead   = !dbg_we;
        end else if (cpu_gnt) begin
            mem_addr      = AW'(word_index(cpu_addr));
            mem_writeData = cpu_wdata;
            mem_memWrite  = cpu_we;
            mem_memRead   = !cpu_we;
        end
    end

    // A burst beat with dbg_lock low is still granted; ownership returns after it.
    always_comb begin
        state_next = state;
        case (state)
            CPU_OWN: if (dbg_gnt && dbg_lock) state_next = DBG_OWN;
            DBG_OWN: if (!dbg_req || !dbg_lock) state_next = CPU_OWN;
            default: state_next = CPU_OWN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CPU_OWN;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            state      <= state_next;
            dbg_rvalid <= dbg_gnt && !dbg_we;
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= mem_readData;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 64-word dmem.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic [63:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic        dbg_lock;
    logic [5:0]  dbg_addr;
    logic [63:0] dbg_wdata;
    logic        dbg_gnt;
    logic [63:0] dbg_rdata;
    logic        dbg_rvalid;
    logic [5:0]  mem_addr;
    logic [63:0] mem_writeData;
    logic        mem_memWrite;
    logic        mem_memRead;
    logic [63:0] mem_readData;

    logic [63:0] mem [0:63];

    int tests_run;
    int tests_failed;

    dmem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_lock     (dbg_lock),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_gnt      (dbg_gnt),
        .dbg_rdata    (dbg_rdata),
        .dbg_rvalid   (dbg_rvalid),
        .mem_addr     (mem_addr),
        .mem_writeData(mem_writeData),
        .mem_memWrite (mem_memWrite),
        .mem_memRead  (mem_memRead),
        .mem_readData (mem_readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dmem: combinational read, write on rising edge, cleared during reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (mem_memWrite) begin
            mem[mem_addr] <= mem_writeData;
        end
    end
    assign mem_readData = mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c_req, input logic c_we, input logic [63:0] c_addr,
                                 input logic [63:0] c_wdata, input logic d_req, input logic d_we,
                                 input logic d_lock, input logic [5:0] d_addr,
                                 input logic [63:0] d_wdata);
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        dbg_req   = d_req;
        dbg_we    = d_we;
        dbg_lock  = d_lock;
        dbg_addr  = d_addr;
        dbg_wdata = d_wdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        applyStimulus(0, 0, 64'h0, 64'h0, 0, 0, 0, 6'd0, 64'h0);
        tick();
        tick();
        checkOutput("rst_rvalid", 64'(dbg_rvalid), 64'h0);
        checkOutput("rst_rdata", dbg_rdata, 64'h0);
        reset = 1'b0;
        #1;
        checkOutput("idle_stall", 64'(cpu_stall), 64'h0);
        checkOutput("idle_we", 64'(mem_memWrite), 64'h0);
        checkOutput("idle_re", 64'(mem_memRead), 64'h0);
        checkOutput("idle_gnt", 64'(dbg_gnt), 64'h0);

        // CPU write 0xAA to byte address 0x18 (word 3)
        tick();
        applyStimulus(1, 1, 64'h18, 64'hAA, 0, 0, 0, 6'd0, 64'h0);
        checkOutput("cw_addr", 64'(mem_addr), 64'h3);
        checkOutput("cw_we", 64'(mem_memWrite), 64'h1);
        checkOutput("cw_re", 64'(mem_memRead), 64'h0);
        checkOutput("cw_wdata", mem_writeData, 64'hAA);
        checkOutput("cw_stall", 64'(cpu_stall), 64'h0);
        tick();

        // CPU read back, upper and low byte-offset bits must be ignored
        applyStimulus(1, 0, 64'hF000_0000_0000_001D, 64'h0, 0, 0, 0, 6'd0, 64'h0);
        checkOutput("cr_addr", 64'(mem_addr), 64'h3);
        checkOutput("cr_re", 64'(mem_memRead), 64'h1);
        checkOutput("cr_rdata", cpu_rdata, 64'hAA);
        tick();

        // Debug read in an idle CPU cycle
        applyStimulus(0, 0, 64'h0, 64'h0, 1, 0, 0, 6'd3, 64'h0);
        checkOutput("dr_gnt", 64'(dbg_gnt), 64'h1);
        checkOutput("dr_addr", 64'(mem_addr), 64'h3);
        tick();
        checkOutput("dr_rvalid", 64'(dbg_rvalid), 64'h1);
        checkOutput("dr_rdata", dbg_rdata, 64'hAA);

        // Contention: CPU reads word 1, debug reads word 3; debug forced on 5th cycle
        applyStimulus(1, 0, 64'h08, 64'h0, 1, 0, 0, 6'd3, 64'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("st%0d_gnt", i), 64'(dbg_gnt), 64'h0);
            checkOutput($sformatf("st%0d_stall", i), 64'(cpu_stall), 64'h0);
            checkOutput($sformatf("st%0d_addr", i), 64'(mem_addr), 64'h1);
            tick();
            checkOutput($sformatf("st%0d_rvalid", i), 64'(dbg_rvalid), 64'h0);
        end
        checkOutput("st_force_gnt", 64'(dbg_gnt), 64'h1);
        checkOutput("st_force_stall", 64'(cpu_stall), 64'h1);
        checkOutput("st_force_addr", 64'(mem_addr), 64'h3);
        tick();
        checkOutput("st_force_rvalid", 64'(dbg_rvalid), 64'h1);
        checkOutput("st_force_rdata", dbg_rdata, 64'hAA);
        applyStimulus(1, 0, 64'h08, 64'h0, 0, 0, 0, 6'd0, 64'h0);
        checkOutput("st_after_stall", 64'(cpu_stall), 64'h0);
        checkOutput("st_after_gnt", 64'(dbg_gnt), 64'h0);
        tick();

        // Locked burst of three debug writes while the CPU keeps requesting
        applyStimulus(1, 0, 64'h08, 64'h0, 1, 1, 1, 6'd0, 64'h10);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("bw%0d_wait_stall", i), 64'(cpu_stall), 64'h0);
            tick();
        end
        checkOutput("b1_gnt", 64'(dbg_gnt), 64'h1);
        checkOutput("b1_stall", 64'(cpu_stall), 64'h1);
        checkOutput("b1_we", 64'(mem_memWrite), 64'h1);
        checkOutput("b1_addr", 64'(mem_addr), 64'h0);
        tick();
        applyStimulus(1, 0, 64'h08, 64'h0, 1, 1, 1, 6'd1, 64'h20);
        checkOutput("b2_gnt", 64'(dbg_gnt), 64'h1);
        checkOutput("b2_stall", 64'(cpu_stall), 64'h1);
        checkOutput("b2_addr", 64'(mem_addr), 64'h1);
        tick();
        applyStimulus(1, 0, 64'h08, 64'h0, 1, 1, 0, 6'd2, 64'h30);
        checkOutput("b3_gnt", 64'(dbg_gnt), 64'h1);
        checkOutput("b3_stall", 64'(cpu_stall), 64'h1);
        checkOutput("b3_wdata", mem_writeData, 64'h30);
        tick();
        checkOutput("b_rvalid", 64'(dbg_rvalid), 64'h0);
        checkOutput("b_rdata_hold", dbg_rdata, 64'hAA);
        applyStimulus(1, 0, 64'h00, 64'h0, 0, 0, 0, 6'd0, 64'h0);
        checkOutput("b_post_stall", 64'(cpu_stall), 64'h0);
        checkOutput("b_mem0", cpu_rdata, 64'h10);
        tick();
        applyStimulus(1, 0, 64'h08, 64'h0, 0, 0, 0, 6'd0, 64'h0);
        checkOutput("b_mem1", cpu_rdata, 64'h20);
        tick();
        applyStimulus(1, 0, 64'h10, 64'h0, 0, 0, 0, 6'd0, 64'h0);
        checkOutput("b_mem2", cpu_rdata, 64'h30);
        tick();

        // Reset in the middle of a locked debug burst
        applyStimulus(0, 0, 64'h0, 64'h0, 1, 0, 1, 6'd2, 64'h0);
        checkOutput("rb_gnt", 64'(dbg_gnt), 64'h1);
        tick();
        checkOutput("rb_rdata", dbg_rdata, 64'h30);
        applyStimulus(1, 0, 64'h00, 64'h0, 1, 0, 1, 6'd1, 64'h0);
        checkOutput("rb_own_stall", 64'(cpu_stall), 64'h1);
        checkOutput("rb_own_gnt", 64'(dbg_gnt), 64'h1);
        reset = 1'b1;
        tick();
        checkOutput("rb_rvalid", 64'(dbg_rvalid), 64'h0);
        checkOutput("rb_rdata0", dbg_rdata, 64'h0);
        reset = 1'b0;
        applyStimulus(1, 0, 64'h00, 64'h0, 1, 0, 0, 6'd1, 64'h0);
        checkOutput("rb_cpu_wins_stall", 64'(cpu_stall), 64'h0);
        checkOutput("rb_cpu_wins_gnt", 64'(dbg_gnt), 64'h0);
        applyStimulus(1, 0, 64'h00, 64'h0, 0, 0, 0, 6'd0, 64'h0);
        checkOutput("rb_cpu_alone", 64'(cpu_stall), 64'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
